act_sched: RTL

- Shares one activation datapath (the 1-cycle registered ReLU stage, 32-bit signed in/out, valid-only, no backpressure) among NUM_REQ requesters.
- Round-robin arbitrates request beats and issues them to the activation unit. Tracks each beat's requester ID through the unit's fixed latency.
- Buffers results in a credit-protected FIFO and returns each result with its ID, under valid/ready backpressure.
- Sits between the accumulator drain ports and the output writeback in the TPU post-processing path.

---
 rtl/act_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/act_sched.sv
// act_sched: shares one activation datapath among NUM_REQ requesters.
//
// Request beats are granted round-robin, issued through a registered stage to
// an external activation unit, and each beat's requester index follows it down
// a tag pipeline that matches the unit latency. Each result is paired with
// its tag and written to a result FIFO. Issue credits are sized to the FIFO, so
// the FIFO can never overflow even when the result consumer stalls.
//
// Handshakes: a beat moves on req_* when req_valid_i[k] && req_ready_o[k].
// A result moves on res_* when res_valid_o && res_ready_i. req_ready_o may
// depend on req_valid_i. A producer must not wait for ready before raising
// valid. The act_* interface is valid-only and has no backpressure.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   req_valid_i/ready_o     per-requester beat handshake (one-hot ready)
//   req_data_i              packed beats, requester k at [k*DATA_W +: DATA_W]
//   act_valid_o/act_data_o  issue to activation unit
//   act_valid_i/act_data_i  result from activation unit
//   res_valid_o/ready_i     result handshake
//   res_data_o/res_id_o     result data and originating requester
//   busy_o                  any beat accepted but not yet popped
//   err_o                   sticky tag/result misalignment
module act_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int ACT_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic                      act_valid_o,
    output logic [DATA_W-1:0]         act_data_o,
    input  logic                      act_valid_i,
    input  logic [DATA_W-1:0]         act_data_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [DATA_W-1:0]         res_data_o,
    output logic [ID_W-1:0]           res_id_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // ---------------- arbitration ----------------
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand;
    logic              grant_found;
    logic [DATA_W-1:0] grant_data;
    logic [CNT_W-1:0]  credits_q, credits_n;
    logic              accept;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) grant_data = req_data_i[k*DATA_W +: DATA_W];
        end
    end

    // A grant is only offered while a FIFO slot is reserved for its result.
    assign accept = grant_found && (credits_q != '0);

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[grant_idx] = 1'b1;
    end

    // ---------------- issue register and tag pipeline ----------------
    logic              act_valid_q;
    logic [DATA_W-1:0] act_data_q;
    logic [ID_W-1:0]   issue_id_q;
    logic [ACT_LAT-1:0] tag_v_q;
    logic [ID_W-1:0]   tag_id_q [ACT_LAT];
    logic              tag_out_v;
    logic [ID_W-1:0]   tag_out_id;

    assign act_valid_o = act_valid_q;
    assign act_data_o  = act_data_q;
    assign tag_out_v   = tag_v_q[ACT_LAT-1];
    assign tag_out_id  = tag_id_q[ACT_LAT-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            act_valid_q <= 1'b0;
            act_data_q  <= '0;
            issue_id_q  <= '0;
            tag_v_q     <= '0;
            for (int s = 0; s < ACT_LAT; s++) tag_id_q[s] <= '0;
        end else begin
            act_valid_q <= accept;
            if (accept) begin
                rr_ptr_q   <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                act_data_q <= grant_data;
                issue_id_q <= grant_idx;
            end
            tag_v_q[0]  <= act_valid_q;
            tag_id_q[0] <= issue_id_q;
            for (int s = 1; s < ACT_LAT; s++) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
        end
    end

    // ---------------- result FIFO and credits ----------------
    logic              fifo_wr, fifo_pop, tag_drop, stray;
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ID_W-1:0]   fifo_id_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic              busy_q, err_q;

    assign fifo_wr  = tag_out_v && act_valid_i;
    assign tag_drop = tag_out_v && !act_valid_i;   // result missing: free its slot
    assign stray    = act_valid_i && !tag_out_v;   // result with no owner: discard
    assign fifo_pop = (fifo_cnt_q != '0) && res_ready_i;

    assign res_valid_o = (fifo_cnt_q != '0);
    assign res_data_o  = fifo_data_q[rd_ptr_q];
    assign res_id_o    = fifo_id_q[rd_ptr_q];
    assign busy_o      = busy_q;
    assign err_o       = err_q;

    // Accept only happens with credits > 0, and returns only happen for
    // outstanding beats, so this net update stays within [0, FIFO_DEPTH].
    always_comb begin
        credits_n = credits_q;
        if (accept)   credits_n = credits_n - CNT_W'(1);
        if (fifo_pop) credits_n = credits_n + CNT_W'(1);
        if (tag_drop) credits_n = credits_n + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            fifo_data_q[wr_ptr_q] <= act_data_i;
            fifo_id_q[wr_ptr_q]   <= tag_out_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            credits_q  <= CNT_W'(FIFO_DEPTH);
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            credits_q <= credits_n;
            busy_q    <= (credits_n != CNT_W'(FIFO_DEPTH));
            err_q     <= err_q | stray | tag_drop;
            if (fifo_wr)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (fifo_pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (fifo_wr && !fifo_pop)      fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            else if (!fifo_wr && fifo_pop) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        end
    end

endmodule
